// File: rtl/bo_bc.sv
// bo_bc: sequential polynomial evaluator, resultado = A*x^2 + B*x + C (mod 2^16).
// Horner form: H = A; H = H*x + B; S = H*x + C.
// The control FSM (BC) drives load enables and mux selects into the datapath (BO).
// The datapath has one truncating multiplier and one wrapping adder.
module bo_bc (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic [7:0]  x,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    output logic [15:0] resultado,
    output logic        pronto
);

    // ------------------------------------------------------------------
    // Control unit (BC)
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep1,
        StStep2,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic lx;  // load X, RB, RC
    logic lh;  // load H
    logic ls;  // load S
    logic m0;  // H source: 0 = coefficient A, 1 = adder output
    logic m1;  // addend: 0 = RB, 1 = RC

    // Next-state and Moore decode of control strobes and pronto
    always_comb begin
        state_d = state_q;
        lx      = 1'b0;
        lh      = 1'b0;
        ls      = 1'b0;
        m0      = 1'b0;
        m1      = 1'b0;
        pronto  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inicio) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                lx      = 1'b1;
                lh      = 1'b1;
                m0      = 1'b0;
                state_d = StStep1;
            end
            StStep1: begin
                lh      = 1'b1;
                m0      = 1'b1;
                m1      = 1'b0;
                state_d = StStep2;
            end
            StStep2: begin
                ls      = 1'b1;
                m1      = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                pronto  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath (BO)
    // ------------------------------------------------------------------
    // H itself holds the A coefficient from LOAD onward, so no separate
    // RA copy is needed for the Horner sequence.
    logic [15:0] x_q,  x_d;
    logic [15:0] rb_q, rb_d;
    logic [15:0] rc_q, rc_d;
    logic [15:0] h_q,  h_d;
    logic [15:0] s_q,  s_d;

    logic [15:0] addend;
    logic [15:0] prod;
    logic [15:0] sum;

    // Function units and register next-state muxing
    always_comb begin
        addend = m1 ? rc_q : rb_q;
        prod   = h_q * x_q;       // 16x16 product, low 16 bits kept
        sum    = prod + addend;   // wraps modulo 2^16

        x_d  = lx ? {8'h00, x} : x_q;
        rb_d = lx ? B : rb_q;
        rc_d = lx ? C : rc_q;
        h_d  = lh ? (m0 ? sum : A) : h_q;
        s_d  = ls ? sum : s_q;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= 16'h0000;
            rb_q    <= 16'h0000;
            rc_q    <= 16'h0000;
            h_q     <= 16'h0000;
            s_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

    assign resultado = s_q;

endmodule

// File: tb/tb_bo_bc.sv
// tb_bo_bc: scoreboard bench for bo_bc. Stimulus pushes the expected result and
// the cycle on which pronto must appear; a negedge monitor pops and compares.
module tb_bo_bc;

    logic        clk;
    logic        rst;
    logic        inicio;
    logic [7:0]  x;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic [15:0] resultado;
    logic        pronto;

    bo_bc dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .x         (x),
        .A         (A),
        .B         (B),
        .C         (C),
        .resultado (resultado),
        .pronto    (pronto)
    );

    typedef struct {
        logic [15:0] exp;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          tests;
    int          fails;
    int          cyc;
    logic [15:0] model_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: direct polynomial in wide integer arithmetic, reduced mod 2^16
    function automatic logic [15:0] poly(input logic [7:0] xv, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
        longint unsigned xl;
        longint unsigned s;
        xl = longint'(xv);
        s  = longint'(a) * xl * xl + longint'(b) * xl + longint'(c);
        return s[15:0];
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // Monitor: compares every pronto pulse against the scoreboard and checks hold
    always @(negedge clk) begin
        if (!rst) begin
            if (pronto === 1'b1) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pronto: got pronto=1 at cycle %0d expected none",
                             cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check16("result", resultado, e.exp);
                    tests++;
                    if (cyc != e.due) begin
                        fails++;
                        $display("FAIL latency: got pronto at cycle %0d expected cycle %0d",
                                 cyc, e.due);
                    end
                    model_res = e.exp;
                end
            end else begin
                if (pronto !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL pronto_level: got %b expected 0", pronto);
                end
                check16("hold", resultado, model_res);
            end
        end
    end

    // One computation starting from IDLE. Returns #1 after the edge back to IDLE.
    task automatic do_run(input logic [7:0] xv, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic keep_high, input logic scramble);
        int   c0;
        exp_t e;
        x      = xv;
        A      = a;
        B      = b;
        C      = c;
        inicio = 1'b1;
        @(posedge clk);  // E0: inicio sampled in IDLE
        #1;
        c0 = cyc;
        @(posedge clk);  // E1: LOAD samples inputs
        #1;
        e.exp = poly(xv, a, b, c);
        e.due = c0 + 3;
        sb_q.push_back(e);
        if (scramble) begin
            x = 8'($urandom);
            A = 16'($urandom);
            B = 16'($urandom);
            C = 16'($urandom);
        end
        if (!keep_high) inicio = 1'b0;
        repeat (3) @(posedge clk);  // E2, E3, E4
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        model_res = 16'h0000;
        rst       = 1'b1;
        inicio    = 1'b0;
        x         = 8'h00;
        A         = 16'h0000;
        B         = 16'h0000;
        C         = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check16("reset_resultado", resultado, 16'h0000);
        check16("reset_pronto", {15'h0, pronto}, 16'h0000);

        // Directed cases
        do_run(8'd2, 16'd5, 16'd3, 16'd4, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_run(8'd0, 16'd7, 16'd9, 16'h1234, 1'b0, 1'b0);
        do_run(8'd1, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0);
        do_run(8'd16, 16'h0100, 16'h0000, 16'h0001, 1'b0, 1'b0);
        do_run(8'd255, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // Inputs forced to zero one cycle into the computation
        x      = 8'd2;
        A      = 16'd5;
        B      = 16'd3;
        C      = 16'd4;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.exp = poly(8'd2, 16'd5, 16'd3, 16'd4);
            e.due = cyc + 3;
            @(posedge clk);  // LOAD
            #1;
            sb_q.push_back(e);
        end
        @(posedge clk);  // STEP1
        #1;
        x      = 8'h00;
        A      = 16'h0000;
        B      = 16'h0000;
        C      = 16'h0000;
        inicio = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted while the FSM is in STEP1
        x      = 8'd9;
        A      = 16'd11;
        B      = 16'd13;
        C      = 16'd17;
        inicio = 1'b1;
        @(posedge clk);  // E0
        @(posedge clk);  // E1: LOAD
        #1;
        inicio = 1'b0;
        rst    = 1'b1;
        @(posedge clk);  // reset applied instead of STEP1
        #1;
        rst       = 1'b0;
        model_res = 16'h0000;
        check16("midreset_resultado", resultado, 16'h0000);
        check16("midreset_pronto", {15'h0, pronto}, 16'h0000);
        do_run(8'd3, 16'd2, 16'd1, 16'd7, 1'b0, 1'b0);

        // Back-to-back with inicio held high and inputs changed between runs
        for (int i = 0; i < 4; i++) begin
            do_run(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   (i != 3), 1'b1);
        end

        // Random runs with random idle gaps, holds and scrambling
        for (int i = 0; i < 20; i++) begin
            logic hold;
            hold = 1'($urandom);
            do_run(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   hold && (i != 19), 1'($urandom));
            if (!hold) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end

        // Drain: every pushed expectation must have been consumed
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
